// File: rtl/stepper_pkg.sv
// Shared stepper definitions: coil phase table, sequencer states, default timing.
// Pure declarations; no latency, no flow control.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DEF_MIN_PERIOD  = 1000;
    localparam int DEF_MAX_PERIOD  = 262143;
    localparam int DEF_HOLD_CYCLES = 500000;

    // Entry 0 is the rightmost nibble; odd entries are the two-coils-on full-step phases.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        return PHASE_TABLE[idx];
    endfunction

endpackage

// File: rtl/step_rate_timer.sv
// Loadable down-counter: clamps the requested period on load, then ticks once every P enabled cycles.
// First tick P cycles after the load edge; no backpressure, counting freezes while disabled.
module step_rate_timer #(
    parameter int PERIOD_W   = 20,
    parameter int MIN_PERIOD = 1000,
    parameter int MAX_PERIOD = 262143
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_en,
    output logic                o_tick
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);

    logic [PERIOD_W-1:0] w_clamped;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_count;

    always_comb begin
        w_clamped = i_period;
        if (i_period < MIN_P)
            w_clamped = MIN_P;
        else if (i_period > MAX_P)
            w_clamped = MAX_P;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period <= MIN_P;
            r_count  <= '0;
        end else if (i_load) begin
            r_period <= w_clamped;
            r_count  <= w_clamped - PERIOD_W'(1);
        end else if (i_en) begin
            if (r_count == '0)
                r_count <= r_period - PERIOD_W'(1);
            else
                r_count <= r_count - PERIOD_W'(1);
        end
    end

    assign o_tick = i_en && (r_count == '0);

endmodule

// File: rtl/step_sequencer.sv
// Stepper move sequencer: walks the coil phase table at a clamped rate, holds, then de-energizes.
// Drive appears the cycle after start, steps every P cycles; start is ignored while stepping, abort wins.
module step_sequencer
    import stepper_pkg::*;
#(
    parameter int PERIOD_W    = 20,
    parameter int COUNT_W     = 16,
    parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int MAX_PERIOD  = DEF_MAX_PERIOD,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_dir,
    input  logic                i_half_step,
    input  logic [COUNT_W-1:0]  i_num_steps,
    input  logic [PERIOD_W-1:0] i_step_period,
    input  logic                i_abort,
    output logic [3:0]          o_drive,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_aborted,
    output logic [COUNT_W-1:0]  o_steps_left,
    output logic [15:0]         o_position
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_idx;
    logic [15:0]         r_pos;
    logic [COUNT_W-1:0]  r_steps_left;
    logic                r_dir;
    logic                r_half;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_done;
    logic                r_aborted;

    logic                w_tick;
    logic                w_capture;
    logic                w_step;
    logic                w_done_set;
    logic                w_abort_set;
    logic [1:0]          w_mag;
    logic [15:0]         w_delta;

    step_rate_timer #(
        .PERIOD_W   (PERIOD_W),
        .MIN_PERIOD (MIN_PERIOD),
        .MAX_PERIOD (MAX_PERIOD)
    ) u_rate (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_capture),
        .i_period (i_step_period),
        .i_en     (r_state == ST_STEP),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_done_set  = 1'b0;
        w_abort_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_capture = 1'b1;
                    if (i_num_steps == '0)
                        w_done_set = 1'b1;
                    else
                        w_next = ST_STEP;
                end
            end
            ST_STEP: begin
                if (i_abort) begin
                    w_next      = ST_IDLE;
                    w_abort_set = 1'b1;
                end else if (w_tick && (r_steps_left == COUNT_W'(1))) begin
                    w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_abort) begin
                    w_next      = ST_IDLE;
                    w_abort_set = 1'b1;
                end else if (i_start) begin
                    // A zero-step command here finishes the held move on the spot.
                    w_capture = 1'b1;
                    if (i_num_steps == '0) begin
                        w_next     = ST_IDLE;
                        w_done_set = 1'b1;
                    end else begin
                        w_next = ST_STEP;
                    end
                end else if (r_hold_cnt == '0) begin
                    w_next     = ST_IDLE;
                    w_done_set = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state != ST_IDLE);
        o_drive      = o_busy ? phase_of(r_idx) : 4'b0000;
        o_done       = r_done;
        o_aborted    = r_aborted;
        o_steps_left = r_steps_left;
        o_position   = r_pos;
    end

    assign w_step = (r_state == ST_STEP) && !i_abort && w_tick;

    // Full-step from an even index takes a single half-step to land on the two-coil phases.
    always_comb begin
        w_mag   = (r_half || !r_idx[0]) ? 2'd1 : 2'd2;
        w_delta = r_dir ? 16'(w_mag) : (16'd0 - 16'(w_mag));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx        <= '0;
            r_pos        <= '0;
            r_steps_left <= '0;
            r_dir        <= 1'b0;
            r_half       <= 1'b0;
            r_hold_cnt   <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_done    <= w_done_set;
            r_aborted <= w_abort_set;
            if (w_capture) begin
                r_steps_left <= i_num_steps;
                r_dir        <= i_dir;
                r_half       <= i_half_step;
            end else if (w_step) begin
                r_steps_left <= r_steps_left - COUNT_W'(1);
            end
            if (w_step) begin
                r_idx <= r_idx + w_delta[2:0];
                r_pos <= r_pos + w_delta;
            end
            if (w_step && (w_next == ST_HOLD))
                r_hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            else if ((r_state == ST_HOLD) && (r_hold_cnt != '0))
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench: the move model predicts every drive change and done/aborted pulse with its cycle.
module tb_step_sequencer;

    localparam int MIN_P = 10;
    localparam int MAX_P = 63;
    localparam int HOLD  = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0, i_dir = 1'b0, i_half_step = 1'b0, i_abort = 1'b0;
    logic [15:0] i_num_steps = '0;
    logic [19:0] i_step_period = '0;
    logic [3:0]  o_drive;
    logic        o_busy, o_done, o_aborted;
    logic [15:0] o_steps_left, o_position;

    step_sequencer #(
        .PERIOD_W(20), .COUNT_W(16), .MIN_PERIOD(MIN_P), .MAX_PERIOD(MAX_P), .HOLD_CYCLES(HOLD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_dir(i_dir), .i_half_step(i_half_step),
        .i_num_steps(i_num_steps), .i_step_period(i_step_period), .i_abort(i_abort),
        .o_drive(o_drive), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
        .o_steps_left(o_steps_left), .o_position(o_position)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  drive;
        logic [15:0] pos;
        logic [15:0] left;
        logic        busy;
        logic        done;
        logic        ab;
    } ev_t;

    ev_t         q[$];
    ev_t         m_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          wd_en = 1'b0;
    int          wd_last = -1;
    logic [3:0]  prev_drive = 4'b0;
    logic [3:0]  tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
    int          m_idx = 0;
    logic [15:0] m_pos = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clampp(input int p);
        if (p < MIN_P) return MIN_P;
        if (p > MAX_P) return MAX_P;
        return p;
    endfunction

    task automatic push_ev(input int c, input logic [3:0] d, input int left, input logic b, dn, ab);
        ev_t e;
        e.cyc = c; e.drive = d; e.pos = m_pos; e.left = 16'(left); e.busy = b; e.done = dn; e.ab = ab;
        q.push_back(e);
    endtask

    // Predicts one move; end_cyc is the done/abort cycle, or the last step cycle when left in HOLD.
    task automatic model_move(input int n0, input int n, input bit d, input bit h, input int praw,
                              input bit from_hold, input int abort_at, input bit leave_hold,
                              output int end_cyc);
        int p, last, k_done, t, step;
        p = clampp(praw);
        if (n == 0) begin
            push_ev(n0 + 1, 4'b0000, 0, 1'b0, 1'b1, 1'b0);
            end_cyc = n0 + 1;
            return;
        end
        if (!from_hold) push_ev(n0 + 1, tbl[m_idx], n, 1'b1, 1'b0, 1'b0);
        last = n0 + 1;
        k_done = 0;
        for (int k = 1; k <= n; k++) begin
            t = n0 + 1 + k * p;
            if (abort_at >= 0 && t > abort_at) break;
            if (h) step = 1;
            else step = (m_idx % 2 == 1) ? 2 : 1;
            if (!d) step = -step;
            m_idx = (m_idx + step + 8) % 8;
            m_pos = m_pos + 16'(step);
            push_ev(t, tbl[m_idx], n - k, 1'b1, 1'b0, 1'b0);
            last = t;
            k_done = k;
        end
        if (abort_at >= 0) begin
            push_ev(abort_at + 1, 4'b0000, n - k_done, 1'b0, 1'b0, 1'b1);
            end_cyc = abort_at + 1;
        end else if (leave_hold) begin
            end_cyc = last;
        end else begin
            push_ev(last + HOLD, 4'b0000, 0, 1'b0, 1'b1, 1'b0);
            end_cyc = last + HOLD;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int n, input bit d, input bit h, input int p, input bit ab, output int n0);
        n0 = cyc;
        i_start = 1'b1; i_dir = d; i_half_step = h; i_num_steps = 16'(n);
        i_step_period = 20'(p); i_abort = ab;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_abort = 1'b0;
    endtask

    task automatic issue_abort(output int a);
        a = cyc;
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_drive", 32'(o_drive), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_aborted", 32'(o_aborted), 32'd0);
        check_eq("rst_steps_left", 32'(o_steps_left), 32'd0);
        check_eq("rst_position", 32'(o_position), 32'd0);
        q.delete();
        m_idx = 0;
        m_pos = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (o_busy !== (o_drive != 4'b0)) begin
                failures++;
                $display("FAIL busy_vs_drive @%0d: busy=%b drive=%b", cyc, o_busy, o_drive);
            end
            if (o_drive !== prev_drive || o_done || o_aborted) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event @%0d: drive=%b done=%b aborted=%b pos=%h, expected none",
                             cyc, o_drive, o_done, o_aborted, o_position);
                end else begin
                    m_e = q.pop_front();
                    if (m_e.cyc != cyc || m_e.drive !== o_drive || m_e.pos !== o_position ||
                        m_e.left !== o_steps_left || m_e.busy !== o_busy || m_e.done !== o_done ||
                        m_e.ab !== o_aborted) begin
                        failures++;
                        $display("FAIL event: got cyc=%0d drive=%b pos=%h left=%0d busy=%b done=%b ab=%b, expected cyc=%0d drive=%b pos=%h left=%0d busy=%b done=%b ab=%b",
                                 cyc, o_drive, o_position, o_steps_left, o_busy, o_done, o_aborted,
                                 m_e.cyc, m_e.drive, m_e.pos, m_e.left, m_e.busy, m_e.done, m_e.ab);
                    end
                end
            end
            if (wd_en && ((o_drive & ~prev_drive) != 4'b0)) begin
                if (wd_last >= 0) begin
                    checks++;
                    if (cyc - wd_last > 2 * MAX_P) begin
                        failures++;
                        $display("FAIL watchdog_gap @%0d: gap=%0d limit=%0d", cyc, cyc - wd_last, 2 * MAX_P);
                    end
                end
                wd_last = cyc;
            end
        end
        prev_drive = o_drive;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, e, e2, a, n, p, span;
        bit d, h;

        do_reset();

        // Half-step forward, three steps at the minimum period.
        issue(3, 1, 1, MIN_P, 0, n0);
        model_move(n0, 3, 1, 1, MIN_P, 0, -1, 0, e);
        run_to(e + 3);
        check_eq("half_fwd_position", 32'(o_position), 32'd3);

        // Full-step reverse from index 0: 1001 then 1100, position -3.
        do_reset();
        issue(2, 0, 0, 25, 0, n0);
        model_move(n0, 2, 0, 0, 25, 0, -1, 0, e);
        run_to(e + 3);
        check_eq("full_rev_position", 32'(o_position), 32'hFFFD);

        // Clamp low and high.
        issue(3, 0, 1, 5, 0, n0);
        model_move(n0, 3, 0, 1, 5, 0, -1, 0, e);
        run_to(e + 3);
        wd_en = 1'b1;
        wd_last = -1;
        issue(16, 1, 1, 20'hFFFFF, 0, n0);
        model_move(n0, 16, 1, 1, 20'hFFFFF, 0, -1, 0, e);
        run_to(e - HOLD + 1);
        wd_en = 1'b0;
        run_to(e + 3);

        // Abort after two steps.
        issue(6, 1, 1, 20, 0, n0);
        model_move(n0, 6, 1, 1, 20, 0, n0 + 46, 0, e);
        run_to(n0 + 46);
        issue_abort(a);
        run_to(e + 6 * 20 + HOLD + 5);

        // Start during STEP is ignored.
        issue(4, 1, 0, 15, 0, n0);
        model_move(n0, 4, 1, 0, 15, 0, -1, 0, e);
        run_to(n0 + 20);
        issue(9, 0, 1, 40, 0, n);
        run_to(e + 3);

        // Restart from HOLD without de-energizing.
        issue(2, 1, 1, 12, 0, n0);
        model_move(n0, 2, 1, 1, 12, 0, -1, 1, e);
        run_to(e + 50);
        issue(3, 0, 0, 11, 0, n0);
        model_move(n0, 3, 0, 0, 11, 1, -1, 0, e2);
        run_to(e2 + 3);

        // Start and abort together in HOLD: abort wins.
        issue(1, 1, 0, 10, 0, n0);
        model_move(n0, 1, 1, 0, 10, 0, -1, 1, e);
        run_to(e + 30);
        issue(5, 1, 1, 10, 1, a);
        push_ev(a + 1, 4'b0000, 0, 1'b0, 1'b0, 1'b1);
        run_to(a + 5);

        // Zero-step command and abort while idle.
        issue(0, 1, 1, 10, 0, n0);
        model_move(n0, 0, 1, 1, 10, 0, -1, 0, e);
        run_to(e + 4);
        issue_abort(a);
        run_to(a + 5);

        // Random moves, some aborted at an arbitrary point of STEP or HOLD.
        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(0, 6);
            d = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            p = $urandom_range(0, 80);
            issue(n, d, h, p, 0, n0);
            if (n != 0 && $urandom_range(0, 2) == 0) begin
                span = n * clampp(p) + HOLD;
                a = n0 + 1 + $urandom_range(0, span - 2);
                model_move(n0, n, d, h, p, 0, a, 0, e);
                run_to(a);
                issue_abort(a);
            end else begin
                model_move(n0, n, d, h, p, 0, -1, 0, e);
            end
            run_to(e + 3);
        end

        // Asynchronous reset in the middle of a move.
        issue(5, 1, 1, 30, 0, n0);
        model_move(n0, 5, 1, 1, 30, 0, -1, 0, e);
        run_to(n0 + 70);
        do_reset();
        run_to(cyc + 10);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover_events: got %0d pending, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
